ring_tx_serializer: RTL and testbench
=====================================

RING_TX_SERIALIZER -- requirements
Module: ring_tx_serializer

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the data word width in bits.
REQ-002 Parameter DIV_W, default 8, SHALL set the bit-period divider width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 in_data  input  WIDTH  SHALL carry the parallel word to transmit.
REQ-006 in_valid  input  1  SHALL indicate that in_data holds a word to transmit.
REQ-007 in_ready  output  1  SHALL be high when the holding register can accept a word.
REQ-008 div  input  DIV_W  SHALL set the bit period to div+1 cycles.
REQ-009 lsb_first  input  1  SHALL select LSB-first order when high and MSB-first when low.
REQ-010 sdo  output  1  SHALL be the serial data output.
REQ-011 sframe  output  1  SHALL be high while sdo carries a valid data bit.
REQ-012 bit_stb  output  1  SHALL pulse for exactly one cycle in the first cycle of each bit.
REQ-013 done  output  1  SHALL pulse for exactly one cycle in the final cycle of each word's last bit.

Function
REQ-014 Datapath SHALL be double-buffered: a one-entry holding register feeds a WIDTH-bit shifter.
REQ-015 Handshake SHALL be: in_ready = !hold_full and !rst; a word is accepted on any edge where in_valid and in_ready are both high.
REQ-016 in_ready SHALL NOT depend combinationally on in_valid.
REQ-017 The FSM SHALL have two states, IDLE and SHIFT.
REQ-018 In IDLE with hold_full set, the next edge SHALL load the shifter from the holding register, clear hold_full, sample div and lsb_first, and enter SHIFT.
REQ-019 Latency SHALL be fixed: for a word accepted at edge N while IDLE, its first bit SHALL appear on sdo after edge N+1.
REQ-020 Each bit SHALL hold sdo stable for exactly div+1 cycles; div=0 gives one bit per cycle.
REQ-021 Bit order SHALL follow the lsb_first value sampled at shifter load: bit WIDTH-1 first when low, bit 0 first when high.
REQ-022 Changes to div and lsb_first SHALL be ignored mid-word.
REQ-023 At the end of the last bit, if hold_full is set, the next word SHALL load on the same edge, with no idle cycle and sframe remaining high.
REQ-024 At the end of the last bit, if hold_full is clear, the FSM SHALL return to IDLE, with sdo=0 and sframe=0.
REQ-025 An accept and a hold-to-shifter transfer SHALL NOT occur on the same edge, because in_ready is low while hold_full is set.
REQ-026 In IDLE, sdo SHALL be 0 and sframe, bit_stb and done SHALL be 0.
REQ-027 The bit counter SHALL count 0..WIDTH-1 and the divider counter SHALL count 0..div, both wrapping to 0.

Reset
REQ-028 While rst is high, in_ready SHALL be 0; after each edge with rst high, sdo, sframe, bit_stb and done SHALL be 0, the FSM SHALL be in IDLE, hold_full SHALL be 0, and all counters SHALL be 0.
REQ-029 Reset asserted mid-word SHALL discard both the shifting word and the held word; no partial bits SHALL follow.
REQ-030 in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-031 The shared package SHALL hold the WIDTH default, the DIV_W default and the FSM state enumeration.
REQ-032 The bit-period divider SHALL be a sub-module, tx_bit_timer (inputs: load, div; outputs: bit_stb, bit_end).
REQ-033 All outputs SHALL be registered, except in_ready.

Verification
REQ-034 Single word, MSB-first: with div=0 and lsb_first=0, accepting 0xA5 at edge N SHALL drive sdo 1,0,1,0,0,1,0,1 after edges N+1..N+8, with done in the eighth cycle and sframe=0 after edge N+9.
REQ-035 Single word, LSB-first: with div=2 and lsb_first=1, sending 0x01 SHALL hold sdo=1 for 3 cycles, then 0 for 21 cycles; bit_stb SHALL pulse 8 times, 3 cycles apart.
REQ-036 Back-to-back: with div=0, sending 0xFF then 0x00 with in_valid held high SHALL give 16 contiguous sframe cycles and a single done pulse per word.
REQ-037 Mid-word config change: changing div from 1 to 5 during bit 3 of 0x3C SHALL leave that word at 2 cycles per bit, and the next word SHALL use 6 cycles per bit.
REQ-038 Mid-word reset: asserting rst during bit 4 of 0xC3 while a held word is pending SHALL force sdo=0 and sframe=0 from the next cycle; no bits of either word SHALL be emitted afterwards, and in_ready SHALL be 1 after rst drops.
REQ-039 Backpressure: with one word shifting and one held, in_ready SHALL stay 0 until the held word transfers; a word presented meanwhile SHALL be accepted only afterwards, with in_data held stable until then.

Source files
------------

// File: rtl/ring_tx_serializer_pkg.sv
// Purpose : shared defaults and FSM state encoding for the ring TX serializer.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
package ring_tx_serializer_pkg;

    localparam int RTS_WIDTH = 8;   // default data word width
    localparam int RTS_DIV_W = 8;   // default bit-period divider width

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } rts_state_t;

endpackage

// File: rtl/tx_bit_timer.sv
// Purpose : bit-period divider; times div+1 cycles per serial bit.
// Latency : flags describe the cycle that follows the current clock edge.
// Backpr. : none; load/stop are obeyed on every edge.
// Ports   : load restarts the period at count 0 and samples div; stop parks the
//           timer; bit_stb/bit_end say the next cycle is the first/last of a bit.
module tx_bit_timer
    import ring_tx_serializer_pkg::*;
#(
    parameter int DIV_W = RTS_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             stop,
    input  logic [DIV_W-1:0] div,
    output logic             bit_stb,
    output logic             bit_end
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;
    logic             r_active;
    logic [DIV_W-1:0] w_cnt_n;
    logic [DIV_W-1:0] w_div_n;
    logic             w_active_n;

    // div is captured only on load so a word keeps its bit period even if
    // the caller changes div mid-word.
    always_comb begin
        w_cnt_n    = r_cnt;
        w_div_n    = r_div;
        w_active_n = r_active;
        if (load) begin
            w_cnt_n    = '0;
            w_div_n    = div;
            w_active_n = 1'b1;
        end else if (stop) begin
            w_cnt_n    = '0;
            w_active_n = 1'b0;
        end else if (r_active) begin
            w_cnt_n = (r_cnt == r_div) ? '0 : r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_div    <= '0;
            r_active <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_n;
            r_div    <= w_div_n;
            r_active <= w_active_n;
        end
    end

    // Look-ahead flags: the parent registers them so its outputs line up
    // with the cycle they describe.
    assign bit_stb = w_active_n && (w_cnt_n == '0);
    assign bit_end = w_active_n && (w_cnt_n == w_div_n);

endmodule

// File: rtl/ring_tx_serializer.sv
// Purpose : double-buffered parallel-to-serial transmitter (holding reg + shifter).
// Latency : word accepted at edge N while idle drives its first bit after edge N+1.
// Backpr. : in_ready low while the holding register is full or rst is high.
// Ports   : in_data/in_valid/in_ready word handshake; div sets div+1 cycles per
//           bit; lsb_first picks bit order; sdo/sframe serial data and frame;
//           bit_stb first cycle of each bit; done final cycle of a word.
module ring_tx_serializer
    import ring_tx_serializer_pkg::*;
#(
    parameter int WIDTH = RTS_WIDTH,
    parameter int DIV_W = RTS_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DIV_W-1:0] div,
    input  logic             lsb_first,
    output logic             sdo,
    output logic             sframe,
    output logic             bit_stb,
    output logic             done
);

    localparam int             BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0]  LAST_BIT = BW'(WIDTH - 1);

    rts_state_t       r_state;
    logic [WIDTH-1:0] r_hold;
    logic             r_hold_full;
    logic [WIDTH-1:0] r_shift;
    logic             r_lsb;
    logic [BW-1:0]    r_bitcnt;
    logic             r_end;       // current cycle is the last of a bit
    logic             r_sdo;
    logic             r_sframe;
    logic             r_bit_stb;
    logic             r_done;

    logic             w_accept;
    logic             w_word_end;
    logic             w_load;
    logic             w_stop;
    logic             w_advance;
    logic [WIDTH-1:0] w_shift_adv;
    logic [BW-1:0]    w_bitcnt_n;
    logic             w_tmr_stb;
    logic             w_tmr_end;

    // Ready depends only on state and rst, never on in_valid.  Because it is
    // low while the holding register is full, an accept and a hold-to-shifter
    // transfer can never land on the same edge.
    assign in_ready    = !r_hold_full && !rst;
    assign w_accept    = in_valid && in_ready;

    assign w_word_end  = (r_state == ST_SHIFT) && r_end && (r_bitcnt == LAST_BIT);
    assign w_load      = r_hold_full && ((r_state == ST_IDLE) || w_word_end);
    assign w_stop      = w_word_end && !r_hold_full;
    assign w_advance   = (r_state == ST_SHIFT) && r_end && !w_word_end;
    assign w_shift_adv = r_lsb ? (r_shift >> 1) : (r_shift << 1);

    always_comb begin
        w_bitcnt_n = r_bitcnt;
        if (w_load || w_stop) begin
            w_bitcnt_n = '0;
        end else if (w_advance) begin
            w_bitcnt_n = r_bitcnt + 1'b1;
        end
    end

    tx_bit_timer #(
        .DIV_W (DIV_W)
    ) u_bit_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (w_load),
        .stop    (w_stop),
        .div     (div),
        .bit_stb (w_tmr_stb),
        .bit_end (w_tmr_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_shift     <= '0;
            r_lsb       <= 1'b0;
            r_bitcnt    <= '0;
            r_end       <= 1'b0;
            r_sdo       <= 1'b0;
            r_sframe    <= 1'b0;
            r_bit_stb   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_bitcnt  <= w_bitcnt_n;
            r_end     <= w_tmr_end;
            r_bit_stb <= w_tmr_stb;
            r_done    <= w_tmr_end && (w_bitcnt_n == LAST_BIT);

            if (w_accept) begin
                r_hold      <= in_data;
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end

            // A load at word end chains the next word with sframe kept high.
            if (w_load) begin
                r_state  <= ST_SHIFT;
                r_shift  <= r_hold;
                r_lsb    <= lsb_first;
                r_sdo    <= lsb_first ? r_hold[0] : r_hold[WIDTH-1];
                r_sframe <= 1'b1;
            end else if (w_stop) begin
                r_state  <= ST_IDLE;
                r_sdo    <= 1'b0;
                r_sframe <= 1'b0;
            end else if (w_advance) begin
                r_shift <= w_shift_adv;
                r_sdo   <= r_lsb ? w_shift_adv[0] : w_shift_adv[WIDTH-1];
            end
        end
    end

    assign sdo     = r_sdo;
    assign sframe  = r_sframe;
    assign bit_stb = r_bit_stb;
    assign done    = r_done;

endmodule

// File: tb/tb_ring_tx_serializer.sv
// Purpose : directed self-checking bench for ring_tx_serializer.
// Latency : inputs driven 1 ns after rising edges, outputs sampled there too.
// Backpr. : exercised by holding in_valid with a full holding register.
module tb_ring_tx_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] div;
    logic       lsb_first;
    logic       sdo;
    logic       sframe;
    logic       bit_stb;
    logic       done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ring_tx_serializer #(
        .WIDTH (8),
        .DIV_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .div       (div),
        .lsb_first (lsb_first),
        .sdo       (sdo),
        .sframe    (sframe),
        .bit_stb   (bit_stb),
        .done      (done)
    );

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; div = 8'd0; lsb_first = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL reset_ready: got %b expected 0", in_ready);
        end
        checks++;
        if ({sdo, sframe, bit_stb, done} !== 4'b0000) begin
            failures++; $display("FAIL reset_outputs: got %b expected 0000", {sdo, sframe, bit_stb, done});
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_release_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_msb_first();
        logic [7:0] w;
        logic       exp_bit;
        w = 8'hA5;
        div = 8'd0; lsb_first = 1'b0; in_data = w; in_valid = 1'b1;
        @(posedge clk); #1;          // edge N: accept
        in_valid = 1'b0;
        checks++;
        if (sframe !== 1'b0 || in_ready !== 1'b0) begin
            failures++; $display("FAIL msb_after_accept: sframe=%b in_ready=%b expected 0 0", sframe, in_ready);
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            exp_bit = w[7-i];
            checks++;
            if (sdo !== exp_bit || sframe !== 1'b1 || bit_stb !== 1'b1 || done !== (i == 7)) begin
                failures++;
                $display("FAIL msb_bit%0d: sdo=%b sframe=%b stb=%b done=%b expected %b 1 1 %b",
                         i, sdo, sframe, bit_stb, done, exp_bit, (i == 7));
            end
        end
        @(posedge clk); #1;
        checks++;
        if ({sdo, sframe, bit_stb, done} !== 4'b0000) begin
            failures++; $display("FAIL msb_idle: got %b expected 0000", {sdo, sframe, bit_stb, done});
        end
    endtask

    task automatic test_lsb_div2();
        int   nstb;
        int   ndone;
        int   done_at;
        logic exp_sdo;
        logic exp_stb;
        nstb = 0; ndone = 0; done_at = -1;
        div = 8'd2; lsb_first = 1'b1; in_data = 8'h01; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            exp_sdo = (i < 3);
            exp_stb = ((i % 3) == 0);
            checks++;
            if (sdo !== exp_sdo || bit_stb !== exp_stb || sframe !== 1'b1) begin
                failures++;
                $display("FAIL lsb_cycle%0d: sdo=%b stb=%b sframe=%b expected %b %b 1",
                         i, sdo, bit_stb, sframe, exp_sdo, exp_stb);
            end
            if (bit_stb === 1'b1) nstb++;
            if (done === 1'b1) begin ndone++; done_at = i; end
        end
        checks++;
        if (nstb != 8) begin
            failures++; $display("FAIL lsb_stb_count: got %0d expected 8", nstb);
        end
        checks++;
        if (ndone != 1 || done_at != 23) begin
            failures++; $display("FAIL lsb_done: count=%0d at=%0d expected 1 at 23", ndone, done_at);
        end
        @(posedge clk); #1;
        checks++;
        if (sframe !== 1'b0 || sdo !== 1'b0) begin
            failures++; $display("FAIL lsb_idle: sframe=%b sdo=%b expected 0 0", sframe, sdo);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [2];
        int   idx, nfr, ndone, nrise, sdo_bad, done_at0, done_at1;
        logic r, prev_fr, exp_bit;
        words[0] = 8'hFF; words[1] = 8'h00;
        idx = 0; nfr = 0; ndone = 0; nrise = 0; sdo_bad = 0; done_at0 = -1; done_at1 = -1;
        div = 8'd0; lsb_first = 1'b0; in_data = words[0]; in_valid = 1'b1;
        prev_fr = sframe;
        for (int c = 0; c < 30; c++) begin
            r = in_ready;
            @(posedge clk); #1;
            if (in_valid && r) begin
                idx++;
                if (idx < 2) in_data = words[idx]; else in_valid = 1'b0;
            end
            if (sframe === 1'b1) begin
                exp_bit = (nfr < 8);
                if (sdo !== exp_bit) sdo_bad++;
                if (done === 1'b1) begin
                    if (ndone == 0) done_at0 = nfr; else done_at1 = nfr;
                    ndone++;
                end
                nfr++;
            end else if (done === 1'b1) begin
                ndone++;
            end
            if (sframe === 1'b1 && prev_fr !== 1'b1) nrise++;
            prev_fr = sframe;
        end
        checks++;
        if (nfr != 16 || nrise != 1) begin
            failures++; $display("FAIL b2b_frame: cycles=%0d runs=%0d expected 16 1", nfr, nrise);
        end
        checks++;
        if (ndone != 2 || done_at0 != 7 || done_at1 != 15) begin
            failures++; $display("FAIL b2b_done: count=%0d at %0d,%0d expected 2 at 7,15", ndone, done_at0, done_at1);
        end
        checks++;
        if (sdo_bad != 0 || idx != 2) begin
            failures++; $display("FAIL b2b_data: bad_bits=%0d accepted=%0d expected 0 2", sdo_bad, idx);
        end
    endtask

    task automatic test_cfg_change();
        logic [7:0]  words [2];
        int          lens [16];
        int          idx, nb, bad0, bad1;
        logic        r, switched;
        logic [15:0] got;
        words[0] = 8'h3C; words[1] = 8'h83;
        idx = 0; nb = 0; bad0 = 0; bad1 = 0; switched = 1'b0; got = '0;
        for (int k = 0; k < 16; k++) lens[k] = 0;
        div = 8'd1; lsb_first = 1'b0; in_data = words[0]; in_valid = 1'b1;
        for (int c = 0; c < 90; c++) begin
            r = in_ready;
            @(posedge clk); #1;
            if (in_valid && r) begin
                idx++;
                if (idx < 2) in_data = words[idx]; else in_valid = 1'b0;
            end
            if (bit_stb === 1'b1) begin
                if (nb < 16) got = {got[14:0], sdo};
                nb++;
            end
            if (sframe === 1'b1 && nb >= 1 && nb <= 16) lens[nb-1]++;
            // change config while bit 3 of the first word is on the wire
            if (nb == 4 && !switched) begin
                div = 8'd5; lsb_first = 1'b1; switched = 1'b1;
            end
        end
        for (int k = 0; k < 8; k++)  if (lens[k] != 2) bad0++;
        for (int k = 8; k < 16; k++) if (lens[k] != 6) bad1++;
        checks++;
        if (got !== 16'h3CC1 || nb != 16) begin
            failures++; $display("FAIL cfg_bits: got %h (%0d bits) expected 3cc1 (16 bits)", got, nb);
        end
        checks++;
        if (bad0 != 0) begin
            failures++; $display("FAIL cfg_word0_period: %0d bits off, bit0 len %0d expected 2", bad0, lens[0]);
        end
        checks++;
        if (bad1 != 0) begin
            failures++; $display("FAIL cfg_word1_period: %0d bits off, bit8 len %0d expected 6", bad1, lens[8]);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0]  words [3];
        int          idx, nb, wait_low;
        logic        r;
        logic [23:0] got;
        words[0] = 8'h96; words[1] = 8'h69; words[2] = 8'hF0;
        idx = 0; nb = 0; wait_low = 0; got = '0;
        div = 8'd1; lsb_first = 1'b0; in_data = words[0]; in_valid = 1'b1;
        for (int c = 0; c < 70; c++) begin
            r = in_ready;
            @(posedge clk); #1;
            if (in_valid && r) begin
                idx++;
                if (idx < 3) in_data = words[idx]; else in_valid = 1'b0;
            end
            if (idx == 2 && in_valid && in_ready !== 1'b1) wait_low++;
            if (bit_stb === 1'b1) begin
                if (nb < 24) got = {got[22:0], sdo};
                nb++;
            end
        end
        checks++;
        if (wait_low != 15) begin
            failures++; $display("FAIL bp_ready_low: got %0d cycles expected 15", wait_low);
        end
        checks++;
        if (idx != 3) begin
            failures++; $display("FAIL bp_accepted: got %0d words expected 3", idx);
        end
        checks++;
        if (got !== 24'h9669F0 || nb != 24) begin
            failures++; $display("FAIL bp_stream: got %h (%0d bits) expected 9669f0 (24 bits)", got, nb);
        end
    endtask

    task automatic test_midword_reset();
        logic [7:0] words [2];
        int   idx, nb, activity;
        logic r;
        words[0] = 8'hC3; words[1] = 8'h5A;
        idx = 0; nb = 0; activity = 0;
        div = 8'd0; lsb_first = 1'b0; in_data = words[0]; in_valid = 1'b1;
        for (int c = 0; c < 20 && nb < 5; c++) begin
            r = in_ready;
            @(posedge clk); #1;
            if (in_valid && r) begin
                idx++;
                if (idx < 2) in_data = words[idx]; else in_valid = 1'b0;
            end
            if (bit_stb === 1'b1) nb++;
        end
        checks++;
        if (nb != 5 || in_ready !== 1'b0 || idx != 2) begin
            failures++; $display("FAIL rst_setup: bits=%0d in_ready=%b accepted=%0d expected 5 0 2", nb, in_ready, idx);
        end
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({sdo, sframe, bit_stb, done} !== 4'b0000) begin
            failures++; $display("FAIL rst_midword_outputs: got %b expected 0000", {sdo, sframe, bit_stb, done});
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL rst_midword_ready: got %b expected 1", in_ready);
        end
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (sdo !== 1'b0 || sframe !== 1'b0 || bit_stb !== 1'b0 || done !== 1'b0) activity++;
        end
        checks++;
        if (activity != 0) begin
            failures++; $display("FAIL rst_no_residue: got %0d active cycles expected 0", activity);
        end
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_div2();
        test_back_to_back();
        test_cfg_change();
        test_backpressure();
        test_midword_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
